f_fetch: RTL and testbench

Fetch stage and IF/ID pipeline register for the five-stage MIPS core. Holds the program counter and computes the next PC from the decode-stage control (`npcOp`, comparator `branch`, jump fields, forwarded `rs`). Hands the fetched instruction and its PC to the decode stage through the IF/ID register. Branches and jumps use one architectural delay slot, so no flush path exists.

---
 rtl/f_fetch_pkg.sv | 20 ++
 rtl/f_npc.sv | 32 +++
 rtl/f_fetch.sv | 66 ++++++
 tb/tb_f_fetch.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/f_fetch_pkg.sv
// Shared definitions for the fetch stage: next-PC select encodings, the reset PC and the
// branch-target helper.
package f_fetch_pkg;

   localparam logic [31:0] PC_RESET_VAL = 32'h0000_3000;

   typedef enum logic [2:0] {
      NpcOpPc4    = 3'd0,
      NpcOpBranch = 3'd1,
      NpcOpJ      = 3'd2,
      NpcOpJr     = 3'd3
   } npc_op_e;

   // Target of a branch sitting in decode; the offset counts words relative to its delay slot.
   function automatic logic [31:0] branch_target(input logic [31:0] d_pc,
                                                 input logic [15:0] off);
      return d_pc + 32'd4 + {{14{off[15]}}, off, 2'b00};
   endfunction

endpackage

// File: rtl/f_npc.sv
// Combinational next-PC select. Control comes from the decode stage, so branch and jump
// targets are relative to D_pc while sequential fetch advances from F_pc.
module f_npc
   import f_fetch_pkg::*;
(
   input  logic [31:0] F_pc,
   input  logic [31:0] D_pc,
   input  logic [25:0] imm26,
   input  logic [31:0] rsData,
   input  logic [2:0]  npcOp,
   input  logic        branch,
   output logic [31:0] npc
);

   logic [31:0] pc_plus4;
   npc_op_e     op;

   assign pc_plus4 = F_pc + 32'd4;
   assign op       = npc_op_e'(npcOp);

   always_comb begin
      npc = pc_plus4;
      case (op)
         NpcOpBranch: npc = branch ? branch_target(D_pc, imm26[15:0]) : pc_plus4;
         NpcOpJ:      npc = {D_pc[31:28], imm26, 2'b00};
         // jr and jalr both take the forwarded rs value unaligned.
         NpcOpJr:     npc = rsData;
         default:     npc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/f_fetch.sv
// Fetch stage: program counter plus the IF/ID pipeline register. Branches and jumps have a
// single delay slot, so the IF/ID register is never flushed.
module f_fetch
   import f_fetch_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_VAL
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [2:0]  npcOp,
   input  logic        branch,
   input  logic [25:0] imm26,
   input  logic [31:0] rsData,
   input  logic [31:0] F_instr,
   output logic [31:0] F_pc,
   output logic [31:0] D_pc,
   output logic [31:0] D_instr,
   output logic [31:0] D_pc8
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] d_pc_q, d_pc_d;
   logic [31:0] d_instr_q, d_instr_d;
   logic [31:0] npc;

   f_npc u_npc (
      .F_pc   (pc_q),
      .D_pc   (d_pc_q),
      .imm26  (imm26),
      .rsData (rsData),
      .npcOp  (npcOp),
      .branch (branch),
      .npc    (npc)
   );

   // A stall holds D, so a pending branch is simply re-evaluated once the stall clears.
   always_comb begin
      pc_d      = pc_q;
      d_pc_d    = d_pc_q;
      d_instr_d = d_instr_q;
      if (!stall) begin
         pc_d      = npc;
         d_pc_d    = pc_q;
         d_instr_d = F_instr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q      <= PC_RESET;
         d_pc_q    <= 32'd0;
         d_instr_q <= 32'd0;
      end else begin
         pc_q      <= pc_d;
         d_pc_q    <= d_pc_d;
         d_instr_q <= d_instr_d;
      end
   end

   assign F_pc    = pc_q;
   assign D_pc    = d_pc_q;
   assign D_instr = d_instr_q;
   assign D_pc8   = d_pc_q + 32'd8;

endmodule

// File: tb/tb_f_fetch.sv
// Bench for f_fetch: directed scenarios plus randomized control, checked against a
// behavioural model of the PC and IF/ID register.
module tb_f_fetch;

   logic        clk = 1'b0;
   logic        reset, stall, branch;
   logic [2:0]  npcOp;
   logic [25:0] imm26;
   logic [31:0] rsData, F_instr, F_pc, D_pc, D_instr, D_pc8;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state.
   logic [31:0] m_pc, m_dpc, m_dinstr;

   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   assign F_instr = imem(F_pc);

   f_fetch dut (
      .clk     (clk),
      .reset   (reset),
      .stall   (stall),
      .npcOp   (npcOp),
      .branch  (branch),
      .imm26   (imm26),
      .rsData  (rsData),
      .F_instr (F_instr),
      .F_pc    (F_pc),
      .D_pc    (D_pc),
      .D_instr (D_instr),
      .D_pc8   (D_pc8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_npc();
      int signed off;
      off = int'($signed(imm26[15:0]));
      case (npcOp)
         3'd1:    return branch ? m_dpc + 32'd4 + 32'(off * 4) : m_pc + 32'd4;
         3'd2:    return {m_dpc[31:28], imm26, 2'b00};
         3'd3:    return rsData;
         default: return m_pc + 32'd4;
      endcase
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".F_pc"}, F_pc, m_pc);
      check({tag, ".D_pc"}, D_pc, m_dpc);
      check({tag, ".D_instr"}, D_instr, m_dinstr);
      check({tag, ".D_pc8"}, D_pc8, m_dpc + 32'd8);
   endtask

   // Apply one cycle of stimulus, advance the model and compare everything.
   task automatic step(input logic rst, input logic stl, input logic [2:0] op,
                       input logic br, input logic [25:0] imm, input logic [31:0] rs,
                       input string tag);
      logic [31:0] nxt;
      reset = rst; stall = stl; npcOp = op; branch = br; imm26 = imm; rsData = rs;
      #1;
      nxt = model_npc();
      @(posedge clk);
      if (rst) begin
         m_pc = 32'h0000_3000; m_dpc = 32'd0; m_dinstr = 32'd0;
      end else if (!stl) begin
         m_dinstr = imem(m_pc);
         m_dpc    = m_pc;
         m_pc     = nxt;
      end
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b1, 3'd1, 1'b1, 26'h3FF_FFFF, 32'hDEAD_BEEF, "rst");
      step(1'b1, 1'b1, 3'd0, 1'b0, 26'd0, 32'd0, "rst");
   endtask

   task automatic run_pc4(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 26'd0, 32'd0, "pc4");
   endtask

   initial begin
      reset = 1'b1; stall = 1'b1; npcOp = 3'd0; branch = 1'b0; imm26 = '0; rsData = '0;
      m_pc = 'x; m_dpc = 'x; m_dinstr = 'x;

      // Reset values and sequential fetch.
      do_reset();
      check("rst_pc", F_pc, 32'h3000);
      check("rst_pc8", D_pc8, 32'd8);
      run_pc4(2);
      check("seq_pc", F_pc, 32'h3008);
      check("seq_dpc", D_pc, 32'h3004);

      // Taken backward branch in D at 3008.
      do_reset();
      run_pc4(3);
      step(1'b0, 1'b0, 3'd1, 1'b1, 26'h000_FFFE, 32'd0, "br_taken");
      check("br_target", F_pc, 32'h3004);
      check("br_slot", D_pc, 32'h300C);

      // Not taken.
      do_reset();
      run_pc4(3);
      step(1'b0, 1'b0, 3'd1, 1'b0, 26'h000_FFFE, 32'd0, "br_nt");
      check("br_nt_pc", F_pc, 32'h3010);

      // j then jr.
      do_reset();
      run_pc4(5);
      step(1'b0, 1'b0, 3'd2, 1'b0, 26'h000_0C10, 32'd0, "j");
      check("j_pc", F_pc, 32'h3040);
      step(1'b0, 1'b0, 3'd3, 1'b0, 26'd0, 32'h3100, "jr");
      check("jr_pc", F_pc, 32'h3100);

      // Taken branch held off by a two-cycle stall.
      do_reset();
      run_pc4(3);
      step(1'b0, 1'b1, 3'd1, 1'b1, 26'h000_FFFE, 32'd0, "stall1");
      check("stall1_pc", F_pc, 32'h300C);
      step(1'b0, 1'b1, 3'd1, 1'b1, 26'h000_FFFE, 32'd0, "stall2");
      check("stall2_dpc", D_pc, 32'h3008);
      step(1'b0, 1'b0, 3'd1, 1'b1, 26'h000_FFFE, 32'd0, "unstall");
      check("unstall_pc", F_pc, 32'h3004);

      // Wrap from the top of the address space, then reset beating a branch.
      step(1'b0, 1'b0, 3'd3, 1'b0, 26'd0, 32'hFFFF_FFFC, "to_top");
      step(1'b0, 1'b0, 3'd0, 1'b0, 26'd0, 32'd0, "wrap");
      check("wrap_pc", F_pc, 32'd0);
      step(1'b1, 1'b0, 3'd1, 1'b1, 26'h000_0040, 32'd0, "rst_br");
      check("rst_br_pc", F_pc, 32'h3000);

      // Randomized control.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
              3'($urandom_range(0, 7)), 1'($urandom), 26'($urandom), $urandom, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
